lfsr_rng_sched: RTL and testbench
=================================

Name: lfsr_rng_sched

Overview:
- Scheduler that shares one XNOR-feedback LFSR instance between NUM_REQ requesters.
- Sequences the LFSR's E/RESET/SEED controls:
  - loads seeds;
  - steps the register OUT_BITS times per request so each delivered word is fresh;
  - returns the word to the round-robin winner.
- Sits between the random-number consumers and the team's LFSR block. The LFSR block loads SEED when E=0 and RESET=1, and shifts once per clock when E=1.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_BITS, 8, LFSR width; must match the attached LFSR instance.
- OUT_BITS, 8, bits per delivered word; also the LFSR steps per word (1..NUM_BITS).
- SEED_DEFAULT, 0, seed loaded after reset and substituted for illegal seeds.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_REQ  request lines, level; hold until GNT.
- GNT  out  NUM_REQ  one-hot grant, high for exactly the VALID cycle.
- VALID  out  1  DATA valid this cycle.
- DATA  out  OUT_BITS  random word; LFSR_Q[OUT_BITS-1:0] while VALID, else 0.
- SEED_LOAD  in  1  one-cycle strobe: reseed with SEED_IN.
- SEED_IN  in  NUM_BITS  new seed, sampled with SEED_LOAD.
- BUSY  out  1  high in any state other than IDLE.
- LFSR_E  out  1  to LFSR E.
- LFSR_RESET  out  1  to LFSR RESET.
- LFSR_SEED  out  NUM_BITS  to LFSR SEED.
- LFSR_Q  in  NUM_BITS  LFSR state (bit 0 = LFSR bit 1).

Behaviour:
- Interface fixed: one clock CLK; RESET synchronous, active-high.
- States: LOAD, IDLE, RUN, DELIVER.
- RESET = 1 forces the following; outputs under reset are GNT=0, VALID=0, DATA=0, BUSY=1, LFSR_E=0, LFSR_RESET=1.
  - state=LOAD;
  - seed register=SEED_DEFAULT;
  - pending-seed flag=0;
  - RR pointer=0;
  - step counter=0.
- Reset mid-RUN or mid-DELIVER aborts the word: no GNT is issued and the LFSR is reloaded with SEED_DEFAULT.
- LOAD (1 cycle):
  - LFSR_E=0, LFSR_RESET=1, LFSR_SEED=seed register;
  - clears the pending flag; goes to IDLE.
- IDLE:
  - LFSR_E=0, LFSR_RESET=0.
  - Priority: SEED_LOAD or pending flag, then REQ.
  - SEED_LOAD this cycle: seed register<=SEED_IN; next state LOAD.
  - Otherwise, if any REQ: latch the winner and set counter=OUT_BITS; next state RUN.
  - Otherwise stay in IDLE.
- Winner selection: first set REQ bit scanning from the RR pointer upward, modulo NUM_REQ.
- RUN:
  - LFSR_E=1 every cycle; counter decrements;
  - after OUT_BITS cycles, go to DELIVER.
- DELIVER (1 cycle):
  - LFSR_E=0, VALID=1, GNT=onehot(winner), DATA=LFSR_Q[OUT_BITS-1:0];
  - RR pointer<=(winner+1) mod NUM_REQ; next state IDLE.
- Latency: REQ high in IDLE cycle 0 → RUN cycles 1..OUT_BITS → VALID in cycle OUT_BITS+1.
  - Minimum spacing between grants is OUT_BITS+2 cycles.
- Winner drops REQ during RUN: the word is still delivered and GNT still pulses.
- SEED_LOAD outside IDLE:
  - seed register<=SEED_IN and the pending flag is set;
  - the current word completes;
  - the next IDLE cycle goes to LOAD ahead of any REQ.
  - A later SEED_LOAD overwrites an earlier pending seed.
- Seed equal to all-ones (XNOR lockup state) is replaced by SEED_DEFAULT when captured.
- REQ=0 everywhere: the block stays in IDLE and the LFSR holds its state.

Optional Feature:
- Macro: LFSR_RNG_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index active REQ always wins; no RR pointer register.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset, then REQ=4'b0001 held → BUSY in cycles 1..9, VALID/GNT=4'b0001 in cycle 9; DATA matches a golden XNOR model stepped 8 times from 0x00; VALID=0 in cycle 10.
- REQ=4'b1111 held for 4 grants → GNT order 0001, 0010, 0100, 1000, spaced 10 cycles apart. With LFSR_RNG_SCHED_FIXED_PRIO_EN, all four grants are 0001.
- SEED_LOAD with SEED_IN=0xA5 in IDLE → one LOAD cycle with LFSR_SEED=0xA5, LFSR_RESET=1. The next word matches the model seeded with 0xA5.
- SEED_LOAD with 0x3C during RUN, REQ[2] also pending → the current word is delivered unchanged, then LOAD with 0x3C, then the REQ[2] grant.
- SEED_LOAD with SEED_IN=0xFF → LFSR_SEED=0x00 (SEED_DEFAULT) during LOAD.
- RESET asserted in RUN cycle 4 → no GNT/VALID; LOAD with 0x00 on the cycle after RESET deasserts; RR pointer back to 0.

Source files
------------

// File: rtl/lfsr_rng_sched.sv
// Arbiter/sequencer sharing one XNOR LFSR among NUM_REQ requesters; steps it OUT_BITS times per word.
// Define LFSR_RNG_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module lfsr_rng_sched #(
    parameter int unsigned         NUM_REQ      = 4,
    parameter int unsigned         NUM_BITS     = 8,
    parameter int unsigned         OUT_BITS     = 8,
    parameter logic [NUM_BITS-1:0] SEED_DEFAULT = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic                o_valid,
    output logic [OUT_BITS-1:0] o_data,
    input  logic                i_seed_load,
    input  logic [NUM_BITS-1:0] i_seed_in,
    output logic                o_busy,
    output logic                o_lfsr_e,
    output logic                o_lfsr_reset,
    output logic [NUM_BITS-1:0] o_lfsr_seed,
    input  logic [NUM_BITS-1:0] i_lfsr_q
);
    localparam int unsigned     IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned     CntW    = $clog2(OUT_BITS + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(OUT_BITS);

    typedef enum logic [1:0] {StLoad, StIdle, StRun, StDeliver} state_t;

    state_t              r_state, w_state_next;
    logic [NUM_BITS-1:0] r_seed, w_seed_next, w_seed_clean;
    logic                r_pending, w_pending_next;
    logic [CntW-1:0]     r_cnt, w_cnt_next;
    logic [IdxW-1:0]     r_winner, w_winner_next, w_pick;

    // All-ones is the XNOR lockup state, so it never reaches the LFSR.
    assign w_seed_clean = (i_seed_in == '1) ? SEED_DEFAULT : i_seed_in;

`ifdef LFSR_RNG_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) w_pick = IdxW'(i);
        end
    end
`else
    localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NUM_REQ);

    logic [IdxW-1:0]    r_rr, w_rr_next, w_off;
    logic [NUM_REQ-1:0] w_req_rot;
    logic [IdxW:0]      w_sum, w_inc;

    // Rotate so the pointer lands at bit 0, take the lowest set bit, then un-rotate.
    always_comb begin
        w_req_rot = NUM_REQ'({i_req, i_req} >> r_rr);
        w_off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) w_off = IdxW'(i);
        end
        w_sum     = {1'b0, r_rr} + {1'b0, w_off};
        w_pick    = (w_sum >= NumReqW) ? IdxW'(w_sum - NumReqW) : IdxW'(w_sum);
        w_inc     = {1'b0, r_winner} + 1'b1;
        w_rr_next = (w_inc >= NumReqW) ? '0 : IdxW'(w_inc);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr <= '0;
        end else if (r_state == StDeliver) begin
            r_rr <= w_rr_next;
        end
    end
`endif

    always_comb begin
        w_state_next   = r_state;
        w_seed_next    = r_seed;
        w_pending_next = r_pending;
        w_cnt_next     = r_cnt;
        w_winner_next  = r_winner;
        o_gnt          = '0;
        o_valid        = 1'b0;
        o_data         = '0;
        o_busy         = 1'b1;
        o_lfsr_e       = 1'b0;
        o_lfsr_reset   = 1'b0;
        o_lfsr_seed    = r_seed;

        unique case (r_state)
            StLoad: begin
                o_lfsr_reset   = 1'b1;
                w_pending_next = 1'b0;
                w_state_next   = StIdle;
            end
            StIdle: begin
                o_busy = 1'b0;
                if (i_seed_load || r_pending) begin
                    w_state_next = StLoad;
                end else if (|i_req) begin
                    w_winner_next = w_pick;
                    w_cnt_next    = CntLoad;
                    w_state_next  = StRun;
                end
            end
            StRun: begin
                o_lfsr_e   = 1'b1;
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt <= CntW'(1)) w_state_next = StDeliver;
            end
            StDeliver: begin
                o_valid      = 1'b1;
                o_gnt        = NUM_REQ'(1) << r_winner;
                o_data       = i_lfsr_q[OUT_BITS-1:0];
                w_state_next = StIdle;
            end
            default: w_state_next = StLoad;
        endcase

        // Outside IDLE the new seed waits until the current word is finished.
        if (i_seed_load) begin
            w_seed_next = w_seed_clean;
            if (r_state != StIdle) w_pending_next = 1'b1;
        end

        // Reset also drives the LFSR directly so an aborted word never leaks out.
        if (i_reset) begin
            o_gnt        = '0;
            o_valid      = 1'b0;
            o_data       = '0;
            o_busy       = 1'b1;
            o_lfsr_e     = 1'b0;
            o_lfsr_reset = 1'b1;
            o_lfsr_seed  = SEED_DEFAULT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StLoad;
            r_seed    <= SEED_DEFAULT;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_winner  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_seed    <= w_seed_next;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
            r_winner  <= w_winner_next;
        end
    end

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// Self-checking bench for lfsr_rng_sched; models the attached XNOR LFSR and the arbitration rules.
module tb_lfsr_rng_sched;
    localparam int NREQ = 4;
    localparam int OUTB = 8;

    logic       clk, rst, seed_load, valid, busy, lfsr_e, lfsr_reset;
    logic [3:0] req, gnt;
    logic [7:0] data, seed_in, lfsr_seed, lfsr_q;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_lfsr;
    int         m_rr;

    lfsr_rng_sched dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req        (req),
        .o_gnt        (gnt),
        .o_valid      (valid),
        .o_data       (data),
        .i_seed_load  (seed_load),
        .i_seed_in    (seed_in),
        .o_busy       (busy),
        .o_lfsr_e     (lfsr_e),
        .o_lfsr_reset (lfsr_reset),
        .o_lfsr_seed  (lfsr_seed),
        .i_lfsr_q     (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit XNOR LFSR, taps 8,6,5,4; bit 0 is LFSR bit 1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
    endfunction

    function automatic logic [7:0] advance(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = lfsr_step(y);
        return y;
    endfunction

    always @(posedge clk) begin
        if (lfsr_e) lfsr_q <= lfsr_step(lfsr_q);
        else if (lfsr_reset) lfsr_q <= lfsr_seed;
    end

    function automatic int exp_winner(input logic [3:0] r, input int rr);
        int idx;
`ifdef LFSR_RNG_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = (rr + k) % NREQ;
            if (r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [7:0] clean_seed(input logic [7:0] s);
        return (s == 8'hFF) ? 8'h00 : s;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; seed_load = 1'b0;
        tick(); tick();
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
        checks++; if (lfsr_e !== 1'b0 || lfsr_reset !== 1'b1) begin
            failures++; $display("FAIL rst_lfsr_ctl got e=%b r=%b exp e=0 r=1", lfsr_e, lfsr_reset);
        end
        rst = 1'b0;
        #1;
        checks++; if (lfsr_reset !== 1'b1 || lfsr_seed !== 8'h00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_load got r=%b seed=%h busy=%b exp r=1 seed=00 busy=1",
                     lfsr_reset, lfsr_seed, busy);
        end
        tick();
        checks++; if (busy !== 1'b0 || lfsr_q !== 8'h00) begin
            failures++; $display("FAIL rst_idle got busy=%b q=%h exp busy=0 q=00", busy, lfsr_q);
        end
        m_lfsr = 8'h00;
        m_rr   = 0;
    endtask

    // From IDLE: present pat, expect the model's winner 9 cycles later with the stepped word.
    task automatic do_word(input logic [3:0] pat, input bit drop_mid);
        int w, lat, e_cnt, b_cnt;
        bit got;
        logic [7:0] st;
        logic [3:0] eg;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL word_idle got busy=%b exp=0", busy); end
        w  = exp_winner(pat, m_rr);
        eg = 4'b1 << w;
        st = advance(m_lfsr, OUTB);
        req = pat; got = 1'b0; lat = 0; e_cnt = 0; b_cnt = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            lat = c;
            if (lfsr_e === 1'b1) e_cnt++;
            if (busy === 1'b1) b_cnt++;
            if (valid === 1'b1) got = 1'b1;
            if (drop_mid && c == 3) req = pat & ~eg;
        end
        checks++; if (!got || lat != OUTB + 1) begin
            failures++; $display("FAIL word_latency got=%0d (valid=%b) exp=%0d", lat, got, OUTB + 1);
        end
        checks++; if (e_cnt != OUTB || b_cnt != lat) begin
            failures++; $display("FAIL word_steps got e=%0d busy=%0d exp e=%0d busy=%0d",
                                 e_cnt, b_cnt, OUTB, lat);
        end
        checks++; if (gnt !== eg) begin failures++; $display("FAIL word_gnt got=%b exp=%b", gnt, eg); end
        checks++; if (data !== st) begin failures++; $display("FAIL word_data got=%h exp=%h", data, st); end
        m_lfsr = st;
        m_rr   = (w + 1) % NREQ;
        req    = '0;
        tick();
        checks++; if (valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL word_after got valid=%b gnt=%b busy=%b exp 0 0000 0",
                                 valid, gnt, busy);
        end
    endtask

    task automatic test_rr();
        int w, lat;
        bit got;
        logic [7:0] st;
        logic [3:0] eg;
        req = 4'hF;
        for (int g = 0; g < 4; g++) begin
            w  = exp_winner(4'hF, m_rr);
            eg = 4'b1 << w;
            st = advance(m_lfsr, OUTB);
            got = 1'b0; lat = 0;
            for (int c = 1; c <= 12 && !got; c++) begin
                tick();
                lat = c;
                if (valid === 1'b1) got = 1'b1;
            end
            checks++; if (!got || lat != ((g == 0) ? OUTB + 1 : OUTB + 2)) begin
                failures++; $display("FAIL rr_spacing grant=%0d got=%0d valid=%b", g, lat, got);
            end
            checks++; if (gnt !== eg) begin
                failures++; $display("FAIL rr_gnt grant=%0d got=%b exp=%b", g, gnt, eg);
            end
            checks++; if (data !== st) begin
                failures++; $display("FAIL rr_data grant=%0d got=%h exp=%h", g, data, st);
            end
            m_lfsr = st;
            m_rr   = (w + 1) % NREQ;
        end
        req = '0;
        tick();
    endtask

    task automatic test_seed_idle(input logic [7:0] s);
        logic [7:0] es;
        es = clean_seed(s);
        seed_load = 1'b1; seed_in = s;
        tick();
        seed_load = 1'b0;
        checks++; if (lfsr_reset !== 1'b1 || lfsr_e !== 1'b0 || lfsr_seed !== es || busy !== 1'b1) begin
            failures++;
            $display("FAIL seed_load_cycle in=%h got r=%b e=%b seed=%h busy=%b exp r=1 e=0 seed=%h busy=1",
                     s, lfsr_reset, lfsr_e, lfsr_seed, busy, es);
        end
        tick();
        checks++; if (busy !== 1'b0 || lfsr_q !== es) begin
            failures++; $display("FAIL seed_loaded got busy=%b q=%h exp busy=0 q=%h", busy, lfsr_q, es);
        end
        m_lfsr = es;
    endtask

    task automatic test_seed_run();
        int w1, w2, lat;
        bit got;
        logic [7:0] st;
        logic [3:0] pat, eg;
        pat = 4'b0101;
        w1  = exp_winner(pat, m_rr);
        eg  = 4'b1 << w1;
        st  = advance(m_lfsr, OUTB);
        req = pat; got = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            if (valid === 1'b1) got = 1'b1;
            seed_load = (c == 3);
            seed_in   = 8'h3C;
        end
        seed_load = 1'b0;
        checks++; if (!got || gnt !== eg || data !== st) begin
            failures++; $display("FAIL seed_run_word got valid=%b gnt=%b data=%h exp 1 %b %h",
                                 got, gnt, data, eg, st);
        end
        m_lfsr = st;
        m_rr   = (w1 + 1) % NREQ;
        req    = pat & ~eg;
        tick();
        tick();
        checks++; if (lfsr_reset !== 1'b1 || lfsr_seed !== 8'h3C || lfsr_e !== 1'b0) begin
            failures++; $display("FAIL seed_run_load got r=%b seed=%h e=%b exp r=1 seed=3c e=0",
                                 lfsr_reset, lfsr_seed, lfsr_e);
        end
        m_lfsr = 8'h3C;
        w2  = exp_winner(req, m_rr);
        eg  = 4'b1 << w2;
        st  = advance(m_lfsr, OUTB);
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            lat = c;
            if (valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got || lat != OUTB + 2 || gnt !== eg || data !== st) begin
            failures++; $display("FAIL seed_run_next got lat=%0d gnt=%b data=%h exp lat=%0d gnt=%b data=%h",
                                 lat, gnt, data, OUTB + 2, eg, st);
        end
        m_lfsr = st;
        m_rr   = (w2 + 1) % NREQ;
        req    = '0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        req = 4'b1010;
        for (int c = 1; c <= 4; c++) tick();
        checks++; if (lfsr_e !== 1'b1) begin failures++; $display("FAIL abort_in_run got e=%b exp=1", lfsr_e); end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (valid !== 1'b0 || gnt !== 4'b0 || lfsr_e !== 1'b0 || lfsr_reset !== 1'b1) begin
                failures++; $display("FAIL abort_rst got valid=%b gnt=%b e=%b r=%b exp 0 0000 0 1",
                                     valid, gnt, lfsr_e, lfsr_reset);
            end
        end
        rst = 1'b0;
        #1;
        checks++; if (lfsr_reset !== 1'b1 || lfsr_seed !== 8'h00 || valid !== 1'b0) begin
            failures++; $display("FAIL abort_load got r=%b seed=%h valid=%b exp r=1 seed=00 valid=0",
                                 lfsr_reset, lfsr_seed, valid);
        end
        req = '0;
        tick();
        checks++; if (lfsr_q !== 8'h00 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_idle got q=%h busy=%b exp q=00 busy=0", lfsr_q, busy);
        end
        m_lfsr = 8'h00;
        m_rr   = 0;
        do_word(4'hF, 1'b0);
    endtask

    task automatic test_random();
        int gap;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                test_seed_idle(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
            end
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++; if (lfsr_e !== 1'b0 || busy !== 1'b0 || lfsr_q !== m_lfsr) begin
                    failures++; $display("FAIL idle_hold got e=%b busy=%b q=%h exp 0 0 %h",
                                         lfsr_e, busy, lfsr_q, m_lfsr);
                end
            end
            do_word(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; seed_load = 1'b0; seed_in = '0;
        test_reset();
        do_word(4'b0001, 1'b0);
        test_reset();
        test_rr();
        test_seed_idle(8'hA5);
        do_word(4'b0010, 1'b0);
        test_seed_idle(8'hFF);
        do_word(4'b1000, 1'b1);
        test_seed_run();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
